// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-addressed data_memory; sub-word stores are done
// as read-modify-write, loads return sign/zero-extended lanes over a valid/ready pair.
module lsu_mem_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] offs, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (offs)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    if (offs[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SZ_BYTE: load_extract = {{24{b[7] & ~uns}}, b};
      SZ_HALF: load_extract = {{16{h[15] & ~uns}}, h};
      SZ_WORD: load_extract = word;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] offs);
    store_merge = word;
    case (size)
      SZ_BYTE: begin
        case (offs)
          2'b00:   store_merge[7:0]   = wd[7:0];
          2'b01:   store_merge[15:8]  = wd[7:0];
          2'b10:   store_merge[23:16] = wd[7:0];
          2'b11:   store_merge[31:24] = wd[7:0];
          default: store_merge = word;
        endcase
      end
      SZ_HALF: begin
        if (offs[1]) begin
          store_merge[31:16] = wd;
        end else begin
          store_merge[15:0] = wd;
        end
      end
      default: store_merge = word;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  offs_q, offs_d;
  logic [15:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_write_en_q, mem_write_en_d;

  logic [31:0] req_idx_s;
  logic        req_err_s;

  assign req_idx_s = {2'b00, req_addr[31:2]};
  assign req_err_s = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_idx_s >= 32'(MEM_WORDS));

  // Next-state and next-output computation for the whole transaction sequencer.
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    uns_d            = uns_q;
    offs_d           = offs_q;
    wdata_d          = wdata_q;
    mem_address_d    = mem_address_q;
    mem_write_en_d   = 1'b0;
    mem_write_data_d = 32'h0000_0000;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = 32'h0000_0000;
    resp_error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d       = req_write;
          size_d        = req_size;
          uns_d         = req_unsigned;
          offs_d        = req_addr[1:0];
          wdata_d       = req_wdata[15:0];
          mem_address_d = req_idx_s;
          if (req_err_s) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            // Full-word stores need no read, so the strobe goes out next cycle.
            state_d          = S_WRITE;
            mem_write_en_d   = 1'b1;
            mem_write_data_d = req_wdata;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (write_q) begin
          state_d          = S_WRITE;
          mem_write_en_d   = 1'b1;
          mem_write_data_d = store_merge(mem_read_data, wdata_q, size_q, offs_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extract(mem_read_data, size_q, offs_q, uns_q);
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered-output flops; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      offs_q           <= 2'b00;
      wdata_q          <= 16'h0000;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'h0000_0000;
      resp_error_q     <= 1'b0;
      mem_address_q    <= 32'h0000_0000;
      mem_write_data_q <= 32'h0000_0000;
      mem_write_en_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      offs_q           <= offs_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_error_q     <= resp_error_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_en_q   <= mem_write_en_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write_en   = mem_write_en_q;

endmodule
